// File: rtl/jbi_min_rq_rdq_rdr_pkg.sv
// jbi_min_rq_rdq_rdr_pkg
//   Shared constants and types for the RDQ reader: beat/entry widths,
//   IQ credit counter width and reset value, FSM state encoding, and a
//   helper returning the index of the final beat for a request length.
package jbi_min_rq_rdq_rdr_pkg;

  localparam int BEAT_W  = 64;
  localparam int ENTRY_W = 128;
  localparam int CRD_W   = 3;
  localparam logic [CRD_W-1:0] CRD_RST = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CRD = 2'd1,
    ST_SEND     = 2'd2
  } state_e;

  // len=0 -> one entry (beats 0..1), len=1 -> four entries (beats 0..7)
  function automatic logic [2:0] last_beat_idx(input logic len);
    return len ? 3'd7 : 3'd1;
  endfunction

endpackage

// File: rtl/jbi_min_rq_rdq_rdr_crd.sv
// jbi_min_rq_rdq_rdr_crd
//   SCTAG IQ credit counter with sticky overflow flag.
//   Ports:
//     cpu_clk, cpu_rst : clock, synchronous active-high reset
//     crd_inc          : SCTAG returned one credit (dequeue)
//     crd_dec          : a request was acknowledged (consumes one credit)
//     credit           : current credit count (resets to CRD_RST)
//     crd_err          : sticky, set when a credit returns while already full
module jbi_min_rq_rdq_rdr_crd
  import jbi_min_rq_rdq_rdr_pkg::*;
(
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             crd_inc,
  input  logic             crd_dec,
  output logic [CRD_W-1:0] credit,
  output logic             crd_err
);

  logic [CRD_W-1:0] credit_q, credit_d;
  logic             crd_err_q, crd_err_d;

  always_comb begin
    credit_d  = credit_q;
    crd_err_d = crd_err_q;
    case ({crd_inc, crd_dec})
      2'b10: begin
        // A return while full is a protocol error: saturate and flag it.
        if (credit_q == CRD_RST) crd_err_d = 1'b1;
        else                     credit_d  = credit_q + 3'd1;
      end
      2'b01:   credit_d = credit_q - 3'd1;
      default: ; // none, or return and consume in the same cycle
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      credit_q  <= CRD_RST;
      crd_err_q <= 1'b0;
    end else begin
      credit_q  <= credit_d;
      crd_err_q <= crd_err_d;
    end
  end

  assign credit  = credit_q;
  assign crd_err = crd_err_q;

endmodule

// File: rtl/jbi_min_rq_rdq_rdr.sv
// jbi_min_rq_rdq_rdr
//   Reads 128-bit RDQ entries and streams them to SCTAG as 64-bit beats
//   (high half first), gated by SCTAG IQ credits.
//   Ports:
//     cpu_clk, cpu_rst      : clock, synchronous active-high reset
//     rdq_avail, rdq_dout   : RDQ non-empty flag and head entry
//     issue_rdq_pop         : pops the RDQ head (with each odd beat)
//     req_vld, req_len      : transfer request (len 0 = 1 entry, 1 = 4 entries)
//     req_ack               : one-cycle request acceptance
//     jbi_sctag_vld/data/last : beat stream to SCTAG
//     jbi_sctag_par         : even parity of data (only with JBI_RDQ_RDR_PARITY_EN)
//     sctag_jbi_iq_dequeue  : SCTAG credit return
//     crd_err               : sticky credit overflow
//   Optional feature macro: JBI_RDQ_RDR_PARITY_EN
module jbi_min_rq_rdq_rdr
  import jbi_min_rq_rdq_rdr_pkg::*;
(
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic               rdq_avail,
  input  logic [ENTRY_W-1:0] rdq_dout,
  output logic               issue_rdq_pop,
  input  logic               req_vld,
  input  logic               req_len,
  output logic               req_ack,
  output logic               jbi_sctag_vld,
  output logic [BEAT_W-1:0]  jbi_sctag_data,
  output logic               jbi_sctag_last,
`ifdef JBI_RDQ_RDR_PARITY_EN
  output logic               jbi_sctag_par,
`endif
  input  logic               sctag_jbi_iq_dequeue,
  output logic               crd_err
);

  state_e           state_q, state_d;
  logic             len_q, len_d;
  logic [2:0]       beat_q, beat_d;
  logic [CRD_W-1:0] credit;

  jbi_min_rq_rdq_rdr_crd u_crd (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .crd_inc (sctag_jbi_iq_dequeue),
    .crd_dec (req_ack),
    .credit  (credit),
    .crd_err (crd_err)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    beat_d         = beat_q;
    req_ack        = 1'b0;
    jbi_sctag_vld  = 1'b0;
    jbi_sctag_data = '0;
    jbi_sctag_last = 1'b0;
    issue_rdq_pop  = 1'b0;
    // Outputs are suppressed while reset is asserted so that a transfer
    // aborted by reset emits no further beat, pop or ack.
    if (!cpu_rst) begin
      case (state_q)
        ST_IDLE: begin
          if (req_vld) begin
            if (credit != '0) begin
              req_ack = 1'b1;
              len_d   = req_len;
              beat_d  = 3'd0;
              state_d = ST_SEND;
            end else begin
              state_d = ST_WAIT_CRD;
            end
          end
        end
        ST_WAIT_CRD: begin
          // A credit arriving this cycle may be consumed immediately.
          if ((credit != '0) || sctag_jbi_iq_dequeue) begin
            req_ack = 1'b1;
            len_d   = req_len;
            beat_d  = 3'd0;
            state_d = ST_SEND;
          end
        end
        ST_SEND: begin
          if (rdq_avail) begin
            jbi_sctag_vld  = 1'b1;
            jbi_sctag_data = beat_q[0] ? rdq_dout[BEAT_W-1:0]
                                       : rdq_dout[ENTRY_W-1:BEAT_W];
            issue_rdq_pop  = beat_q[0];
            if (beat_q == last_beat_idx(len_q)) begin
              jbi_sctag_last = 1'b1;
              beat_d         = 3'd0;
              state_d        = ST_IDLE;
            end else begin
              beat_d = beat_q + 3'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= ST_IDLE;
      len_q   <= 1'b0;
      beat_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

`ifdef JBI_RDQ_RDR_PARITY_EN
  // Data is forced to zero when not valid, so parity is zero then as well.
  assign jbi_sctag_par = ^jbi_sctag_data;
`endif

endmodule

// File: doc/jbi_min_rq_rdq_rdr.md
JBI_MIN_RQ_RDQ_RDR -- requirements
Module: jbi_min_rq_rdq_rdr

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports listed clock and reset first.
REQ-002 cpu_clk  in  1  CPU-domain clock; all state SHALL update on its rising edge.
REQ-003 cpu_rst  in  1  synchronous active-high reset.
REQ-004 rdq_avail  in  1  RDQ non-empty; rdq_dout holds the head entry.
REQ-005 rdq_dout  in  128  RDQ head entry data; valid only while rdq_avail=1.
REQ-006 issue_rdq_pop  out  1  pulse; advances the RDQ read pointer by one entry.
REQ-007 req_vld  in  1  issue arbiter requests a data transfer.
REQ-008 req_len  in  1  0 = 1 entry (16B), 1 = 4 entries (64B).
REQ-009 req_ack  out  1  one-cycle pulse; request accepted and len captured.
REQ-010 jbi_sctag_vld  out  1  data beat valid to SCTAG.
REQ-011 jbi_sctag_data  out  64  data beat.
REQ-012 jbi_sctag_last  out  1  final beat of the transfer.
REQ-013 sctag_jbi_iq_dequeue  in  1  SCTAG returns one IQ credit.
REQ-014 crd_err  out  1  sticky credit overflow flag.

Function
REQ-015 The credit counter SHALL be 3 bits, reset to 4, +1 on dequeue, -1 on req_ack; both in one cycle leaves it unchanged.
REQ-016 Dequeue with credit=4 and no req_ack SHALL leave the count at 4 and set crd_err until reset.
REQ-017 FSM states: IDLE, WAIT_CRD, SEND.
REQ-018 IDLE: req_vld and credit>0 -> req_ack=1, len captured, beat counter cleared, go to SEND; req_vld and credit=0 -> WAIT_CRD.
REQ-019 WAIT_CRD: a credit of at least 1 (including a same-cycle dequeue) -> req_ack=1 and SEND; otherwise hold.
REQ-020 SEND: a beat SHALL issue only in a cycle where rdq_avail=1; otherwise jbi_sctag_vld=0 and the beat counter holds.
REQ-021 Each entry SHALL go out as two beats: rdq_dout[127:64] on the even beat, then rdq_dout[63:0] on the odd beat.
REQ-022 issue_rdq_pop SHALL assert in the same cycle as each odd beat, and at no other time.
REQ-023 Beat count: 2 beats for len=0, 8 beats for len=1; the 3-bit beat counter SHALL wrap only at transfer end.
REQ-024 jbi_sctag_last SHALL assert with the final beat; the FSM SHALL then enter IDLE.
REQ-025 A new req_ack SHALL NOT occur in the cycle of a last beat; the minimum request-to-request gap is one IDLE cycle.
REQ-026 Outputs SHALL be combinational from FSM state, counters and rdq_dout; there is zero latency from rdq_avail to a beat.
REQ-027 jbi_sctag_data SHALL be 0 whenever jbi_sctag_vld=0.

Reset
REQ-028 During reset: FSM=IDLE, credit=4, beat counter=0, crd_err=0.
REQ-029 During reset: issue_rdq_pop=0, req_ack=0, jbi_sctag_vld=0, jbi_sctag_last=0, jbi_sctag_data=0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no further pop or beat; credits are not refunded beyond the reset value.

Configuration
REQ-031 With JBI_RDQ_RDR_PARITY_EN defined, output jbi_sctag_par (1 bit) SHALL carry even parity of jbi_sctag_data, and be 0 when vld=0.
REQ-032 Without JBI_RDQ_RDR_PARITY_EN, the port and its logic SHALL be absent.

Structure
REQ-033 The following SHALL live in jbi.h: beat width (64), entry width (128), credit reset value (4), credit width (3), and FSM state encodings.
REQ-034 The credit counter and crd_err SHALL be the sub-module jbi_min_rq_rdq_rdr_crd.

Verification
REQ-035 Reset, then req_vld=1, req_len=1, rdq_avail=1 with 4 entries -> req_ack next edge; 8 beats high/low per entry; pops on beats 1,3,5,7; last on beat 7; credit=3.
REQ-036 len=0 with rdq_avail toggling 1,0,1 -> beat0, stall cycle (vld=0), beat1 with pop and last.
REQ-037 Four back-to-back acked requests, fifth req_vld -> WAIT_CRD, no ack; one dequeue pulse -> ack in that same cycle.
REQ-038 Dequeue and req_ack in the same cycle with credit=2 -> credit stays 2.
REQ-039 Dequeue with credit=4 while idle -> crd_err=1 and held; cpu_rst -> crd_err=0.
REQ-040 cpu_rst asserted after beat 3 of an 8-beat transfer -> no further vld or pop; IDLE, credit=4 next cycle; with PARITY_EN, par matches ^data on every beat.
